// File: rtl/pc_pkg.sv
// Shared types and default sizes for the program-counter sequencer.
package pc_pkg;

   localparam int PC_WIDTH_DFT = 32;
   localparam int PC_STEP_DFT  = 1;
   localparam int RAS_DEPTH_DFT = 8;

   typedef enum logic [1:0] {
      PC_SRC_DFT = 2'b00,
      PC_SRC_RA  = 2'b01,
      PC_SRC_JMP = 2'b10,
      PC_SRC_BTA = 2'b11
   } pc_src_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: pop-then-push in one cycle, oldest entry
// is overwritten when a push arrives while full.
module ras_stack #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int               PTR_W     = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] sp, sp_popped;
   logic [PTR_W:0]   count, count_popped, count_next;
   logic             pop_ok;

   always_comb begin
      pop_ok       = pop && (count != '0);
      sp_popped    = pop_ok ? sp - PTR_ONE : sp;
      count_popped = pop_ok ? count - CNT_ONE : count;
      count_next   = count_popped;
      if (push && (count_popped != DEPTH_CNT))
         count_next = count_popped + CNT_ONE;
   end

   assign top = mem[sp - PTR_ONE];

   always_ff @(posedge clock) begin
      if (reset) begin
         sp       <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         sp       <= push ? sp_popped + PTR_ONE : sp_popped;
         count    <= count_next;
         empty    <= (count_next == '0);
         full     <= (count_next == DEPTH_CNT);
         if (push && (count_popped == DEPTH_CNT))
            overflow <= 1'b1;
      end
   end

   // NOTE: storage has no reset; clearing count/sp is enough to discard it.
   always_ff @(posedge clock) begin
      if (push && !reset)
         mem[sp_popped] <= push_data;
   end

endmodule

// File: rtl/pc_sequencer_ras.sv
// Program counter with next-PC select and internal return-address stack.
// Optional target alignment check enabled by PC_ALIGN_CHECK_EN.
module pc_sequencer_ras
   import pc_pkg::*;
#(
   parameter int                  PC_WIDTH  = PC_WIDTH_DFT,
   parameter int                  RAS_DEPTH = RAS_DEPTH_DFT,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter int                  PC_STEP   = PC_STEP_DFT
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                pc_write,
   input  pc_src_t             pc_src,
   input  logic [PC_WIDTH-1:0] i_imm,
   input  logic [PC_WIDTH-1:0] j_imm,
   input  logic [PC_WIDTH-1:0] reg_ra,
   input  logic                call,
   output logic [PC_WIDTH-1:0] pc,
   output logic                ras_empty,
   output logic                ras_full,
   output logic                ras_overflow,
`ifdef PC_ALIGN_CHECK_EN
   output logic                misalign,
`endif
   output logic                ras_fallback
);

   localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

   logic [PC_WIDTH-1:0] target, ras_top;
   logic                bad_align, do_update, take_fallback, push, pop;

`ifdef PC_ALIGN_CHECK_EN
   localparam int                  ALIGN_BITS = $clog2(PC_STEP);
   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'((64'(1) << ALIGN_BITS) - 64'(1));
   assign bad_align = pc_write && ((target & ALIGN_MASK) != '0);
`else
   assign bad_align = 1'b0;
`endif

   // NOTE: every variable gets a default so this block can never infer a latch.
   always_comb begin
      target = pc + STEP;
      unique case (pc_src)
         PC_SRC_DFT: target = pc + STEP;
         PC_SRC_JMP: target = pc + j_imm;
         PC_SRC_BTA: target = pc + i_imm;
         PC_SRC_RA:  target = ras_empty ? reg_ra : ras_top;
         default:    target = pc + STEP;
      endcase
   end

   assign do_update     = pc_write && !bad_align && !reset;
   assign pop           = do_update && (pc_src == PC_SRC_RA);
   assign push          = do_update && call;
   assign take_fallback = pop && ras_empty;

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (PC_WIDTH)
   ) u_ras (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (pc + STEP),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (ras_overflow)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc           <= RESET_PC;
         ras_fallback <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
         misalign     <= 1'b0;
`endif
      end else begin
         ras_fallback <= take_fallback;
         if (do_update)
            pc <= target;
`ifdef PC_ALIGN_CHECK_EN
         misalign     <= bad_align;
`endif
      end
   end

endmodule

// File: tb/tb_pc_sequencer_ras.sv
// Self-checking bench for pc_sequencer_ras: directed scenarios then random
// traffic, compared against a queue-based reference model.
module tb_pc_sequencer_ras;
   import pc_pkg::*;

   localparam int              W    = 32;
   localparam int              D    = 8;
   localparam int              STEP = 1;
   localparam logic [W-1:0]    RPC  = '0;

   logic          clock, reset, pc_write, call;
   pc_src_t       pc_src;
   logic [W-1:0]  i_imm, j_imm, reg_ra, pc;
   logic          ras_empty, ras_full, ras_overflow, ras_fallback;
`ifdef PC_ALIGN_CHECK_EN
   logic          misalign;
`endif

   pc_sequencer_ras #(
      .PC_WIDTH  (W),
      .RAS_DEPTH (D),
      .RESET_PC  (RPC),
      .PC_STEP   (STEP)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .i_imm        (i_imm),
      .j_imm        (j_imm),
      .reg_ra       (reg_ra),
      .call         (call),
      .pc           (pc),
      .ras_empty    (ras_empty),
      .ras_full     (ras_full),
      .ras_overflow (ras_overflow),
`ifdef PC_ALIGN_CHECK_EN
      .misalign     (misalign),
`endif
      .ras_fallback (ras_fallback)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int step_no = 0;

   // Reference model: the stack is a queue, newest entry at the back.
   logic [W-1:0] m_pc;
   logic [W-1:0] m_q[$];
   bit           m_ovf, m_fb;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp);
      end
   endtask

   task automatic model(input bit rst, input bit pw, input pc_src_t src,
                        input logic [W-1:0] i, input logic [W-1:0] j,
                        input logic [W-1:0] ra, input bit cl);
      logic [W-1:0] nxt;
      if (rst) begin
         m_pc = RPC;
         m_q.delete();
         m_ovf = 1'b0;
         m_fb  = 1'b0;
      end else if (!pw) begin
         m_fb = 1'b0;
      end else begin
         m_fb = 1'b0;
         case (src)
            PC_SRC_JMP: nxt = m_pc + j;
            PC_SRC_BTA: nxt = m_pc + i;
            PC_SRC_RA:
               if (m_q.size() > 0) nxt = m_q.pop_back();
               else begin
                  nxt  = ra;
                  m_fb = 1'b1;
               end
            default:    nxt = m_pc + W'(STEP);
         endcase
         if (cl) begin
            m_q.push_back(m_pc + W'(STEP));
            if (m_q.size() > D) begin
               void'(m_q.pop_front());
               m_ovf = 1'b1;
            end
         end
         m_pc = nxt;
      end
   endtask

   task automatic step(input bit rst, input bit pw, input pc_src_t src,
                       input logic [W-1:0] i, input logic [W-1:0] j,
                       input logic [W-1:0] ra, input bit cl);
      reset    = rst;
      pc_write = pw;
      pc_src   = src;
      i_imm    = i;
      j_imm    = j;
      reg_ra   = ra;
      call     = cl;
      model(rst, pw, src, i, j, ra, cl);
      @(posedge clock);
      #1;
      step_no++;
      check("pc", pc, m_pc);
      check("ras_empty", W'(ras_empty), W'(m_q.size() == 0));
      check("ras_full", W'(ras_full), W'(m_q.size() == D));
      check("ras_overflow", W'(ras_overflow), W'(m_ovf));
      check("ras_fallback", W'(ras_fallback), W'(m_fb));
`ifdef PC_ALIGN_CHECK_EN
      check("misalign", W'(misalign), '0);
`endif
   endtask

   initial begin
      reset = 1'b1; pc_write = 1'b0; pc_src = PC_SRC_DFT; call = 1'b0;
      i_imm = '0; j_imm = '0; reg_ra = '0;

      // Reset and sequential fetch
      step(1, 0, PC_SRC_DFT, 0, 0, 0, 0);
      check("reset_pc", pc, RPC);
      check("reset_empty", W'(ras_empty), W'(1));
      for (int k = 0; k < 3; k++) step(0, 1, PC_SRC_DFT, 0, 0, 0, 0);
      check("dft_pc3", pc, W'(3));

      // Jump, branch back, hold (call ignored while held)
      step(0, 1, PC_SRC_JMP, 0, W'(10), 0, 0);
      check("jmp_pc13", pc, W'(13));
      step(0, 1, PC_SRC_BTA, W'(-5), 0, 0, 0);
      check("bta_pc8", pc, W'(8));
      step(0, 0, PC_SRC_JMP, 0, W'(7), 0, 0);
      step(0, 0, PC_SRC_DFT, 0, 0, 0, 1);
      check("hold_pc8", pc, W'(8));

      // Call / return / fallback
      step(0, 1, PC_SRC_JMP, 0, W'(100), 0, 1);
      check("call_pc108", pc, W'(108));
      step(0, 1, PC_SRC_RA, 0, 0, W'(77), 0);
      check("ret_pc9", pc, W'(9));
      step(0, 1, PC_SRC_RA, 0, 0, W'(2), 0);
      check("fallback_pc2", pc, W'(2));
      check("fallback_pulse", W'(ras_fallback), W'(1));
      step(0, 1, PC_SRC_DFT, 0, 0, 0, 0);

      // Overflow: 9 calls from pc=0, then 8 returns
      step(1, 0, PC_SRC_DFT, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++) step(0, 1, PC_SRC_DFT, 0, 0, 0, 1);
      check("ovf_full", W'(ras_full), W'(1));
      check("ovf_flag", W'(ras_overflow), W'(1));
      for (int k = 0; k < 8; k++) step(0, 1, PC_SRC_RA, 0, 0, W'(555), 0);
      check("pop_last_pc2", pc, W'(2));
      check("pop_empty", W'(ras_empty), W'(1));

      // Wrap, simultaneous pop+push, reset during push
      step(0, 1, PC_SRC_JMP, 0, W'(32'hFFFF_FFFF) - pc, 0, 0);
      step(0, 1, PC_SRC_DFT, 0, 0, 0, 0);
      check("wrap_pc0", pc, W'(0));
      step(0, 1, PC_SRC_JMP, 0, W'(49), 0, 0);
      step(0, 1, PC_SRC_JMP, 0, W'(-29), 0, 1);
      step(0, 1, PC_SRC_RA, 0, 0, W'(3), 1);
      check("poppush_pc50", pc, W'(50));
      step(0, 1, PC_SRC_RA, 0, 0, W'(3), 0);
      check("poppush_top21", pc, W'(21));
      step(1, 1, PC_SRC_DFT, 0, 0, 0, 1);
      check("rst_mid_ovf", W'(ras_overflow), W'(0));

      // Random traffic against the model
      for (int k = 0; k < 600; k++) begin
         logic [W-1:0] ri, rj;
         ri = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 63)) - W'(32);
         rj = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 63)) - W'(32);
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
              pc_src_t'($urandom_range(0, 3)), ri, rj, W'($urandom),
              $urandom_range(0, 2) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
